// File: rtl/axi_master_txn_engine.sv
// rtl/axi_master_txn_engine.sv - AXI4 master transaction engine issuing INCR bursts from a command port
//
// Purpose:
//   Turns read/write commands into AXI4 INCR bursts (AW/W/B, AR/R), keeps
//   per-direction outstanding counts and reports completions on one-cycle
//   write/read response strobes. Write and read paths run independently.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   cmd_*                         command handshake and fields (write/read, addr, len, size, id, seed)
//   aw*, w*, b*                   AXI4 write address / data / response channels
//   ar*, r*                       AXI4 read address / data channels
//   wrsp_valid/id/resp            write completion pulse
//   rrsp_valid/id/resp/data       read completion pulse (worst RRESP, last-beat data)
//   wr_outstanding, rd_outstanding live issued-but-incomplete counts
//   timeout_err                   sticky handshake watchdog flag
//
// Optional feature: define AXI_MASTER_TIMEOUT_EN to build the AW/W/AR
// handshake watchdog; otherwise timeout_err is tied low.

module axi_master_txn_engine #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int ID_W            = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                clk,
   input  logic                rstn,

   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [7:0]          cmd_len,
   input  logic [2:0]          cmd_size,
   input  logic [ID_W-1:0]     cmd_id,
   input  logic [DATA_W-1:0]   cmd_seed,

   output logic [ID_W-1:0]     awid,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic                awvalid,
   input  logic                awready,

   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,

   input  logic [ID_W-1:0]     bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,

   output logic [ID_W-1:0]     arid,
   output logic [ADDR_W-1:0]   araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic                arvalid,
   input  logic                arready,

   input  logic [ID_W-1:0]     rid,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,

   output logic                wrsp_valid,
   output logic [ID_W-1:0]     wrsp_id,
   output logic [1:0]          wrsp_resp,

   output logic                rrsp_valid,
   output logic [ID_W-1:0]     rrsp_id,
   output logic [1:0]          rrsp_resp,
   output logic [DATA_W-1:0]   rrsp_data,

   output logic [3:0]          wr_outstanding,
   output logic [3:0]          rd_outstanding,
   output logic                timeout_err
);

   localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
   localparam logic [3:0] MAX_OUT  = 4'(MAX_OUTSTANDING);
   localparam int         NUM_ID   = 1 << ID_W;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wr_state_e;
   typedef enum logic       {R_IDLE, R_ADDR}         rd_state_e;

   // live_q rises on the first clock after reset release; it keeps bready,
   // rready, cmd_ready and the constant burst type at 0 while in reset.
   logic live_q;

   wr_state_e           wr_state_q, wr_state_d;
   logic [ID_W-1:0]     aw_id_q, aw_id_d;
   logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
   logic [7:0]          aw_len_q, aw_len_d;
   logic [2:0]          aw_size_q, aw_size_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [7:0]          beat_q, beat_d;

   rd_state_e           rd_state_q, rd_state_d;
   logic [ID_W-1:0]     ar_id_q, ar_id_d;
   logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
   logic [7:0]          ar_len_q, ar_len_d;
   logic [2:0]          ar_size_q, ar_size_d;

   logic [3:0]          wr_out_q, wr_out_d;
   logic [3:0]          rd_out_q, rd_out_d;

   logic                wrsp_valid_q;
   logic [ID_W-1:0]     wrsp_id_q;
   logic [1:0]          wrsp_resp_q;
   logic                rrsp_valid_q;
   logic [ID_W-1:0]     rrsp_id_q;
   logic [1:0]          rrsp_resp_q;
   logic [DATA_W-1:0]   rrsp_data_q;
   logic [1:0]          acc_q [NUM_ID];

   logic                wr_can, rd_can;
   logic                wr_accept, rd_accept;
   logic                aw_hs, w_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last_hs;
   logic [2:0]          size_clamped;
   logic [1:0]          r_worst;

   // ---------------------------------------------------------------- handshakes
   assign wr_can    = (wr_state_q == W_IDLE) && (wr_out_q < MAX_OUT);
   assign rd_can    = (rd_state_q == R_IDLE) && (rd_out_q < MAX_OUT);
   assign cmd_ready = live_q && (cmd_write ? wr_can : rd_can);

   assign wr_accept = cmd_valid && cmd_ready && cmd_write;
   assign rd_accept = cmd_valid && cmd_ready && !cmd_write;

   assign aw_hs     = awvalid && awready;
   assign w_hs      = wvalid && wready;
   assign w_last_hs = w_hs && wlast;
   assign b_hs      = bvalid && bready;
   assign ar_hs     = arvalid && arready;
   assign r_hs      = rvalid && rready;
   assign r_last_hs = r_hs && rlast;

   assign size_clamped = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;

   // ---------------------------------------------------------------- write FSM
   always_comb begin
      wr_state_d = wr_state_q;
      aw_id_d    = aw_id_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      wdata_d    = wdata_q;
      beat_d     = beat_q;
      case (wr_state_q)
         W_IDLE: begin
            if (wr_accept) begin
               aw_id_d    = cmd_id;
               aw_addr_d  = cmd_addr;
               aw_len_d   = cmd_len;
               aw_size_d  = size_clamped;
               wdata_d    = cmd_seed;
               beat_d     = 8'd0;
               wr_state_d = W_ADDR;
            end
         end
         W_ADDR: begin
            if (aw_hs) begin
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs) begin
               // Data word tracks the beat index: seed + i, wrapping naturally.
               wdata_d = wdata_q + DATA_W'(1);
               beat_d  = beat_q + 8'd1;
               if (w_last_hs) begin
                  wr_state_d = W_IDLE;
               end
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- read FSM
   always_comb begin
      rd_state_d = rd_state_q;
      ar_id_d    = ar_id_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      case (rd_state_q)
         R_IDLE: begin
            if (rd_accept) begin
               ar_id_d    = cmd_id;
               ar_addr_d  = cmd_addr;
               ar_len_d   = cmd_len;
               ar_size_d  = size_clamped;
               rd_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            if (ar_hs) begin
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outstanding counters
   // A completion with nothing outstanding is reported but never underflows.
   always_comb begin
      wr_out_d = wr_out_q;
      case ({aw_hs, b_hs})
         2'b10:   wr_out_d = wr_out_q + 4'd1;
         2'b01:   wr_out_d = (wr_out_q != 4'd0) ? wr_out_q - 4'd1 : 4'd0;
         default: wr_out_d = wr_out_q;
      endcase
   end

   always_comb begin
      rd_out_d = rd_out_q;
      case ({ar_hs, r_last_hs})
         2'b10:   rd_out_d = rd_out_q + 4'd1;
         2'b01:   rd_out_d = (rd_out_q != 4'd0) ? rd_out_q - 4'd1 : 4'd0;
         default: rd_out_d = rd_out_q;
      endcase
   end

   // Worst response so far for this ID, including the beat on the bus now.
   assign r_worst = (rresp > acc_q[rid]) ? rresp : acc_q[rid];

   // ---------------------------------------------------------------- state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         live_q     <= 1'b0;
         wr_state_q <= W_IDLE;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         wdata_q    <= '0;
         beat_q     <= '0;
         rd_state_q <= R_IDLE;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         wr_out_q   <= '0;
         rd_out_q   <= '0;
      end else begin
         live_q     <= 1'b1;
         wr_state_q <= wr_state_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         wdata_q    <= wdata_d;
         beat_q     <= beat_d;
         rd_state_q <= rd_state_d;
         ar_id_q    <= ar_id_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         wr_out_q   <= wr_out_d;
         rd_out_q   <= rd_out_d;
      end
   end

   // ---------------------------------------------------------------- response registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wrsp_valid_q <= 1'b0;
         wrsp_id_q    <= '0;
         wrsp_resp_q  <= '0;
      end else begin
         wrsp_valid_q <= b_hs;
         if (b_hs) begin
            wrsp_id_q   <= bid;
            wrsp_resp_q <= bresp;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rrsp_valid_q <= 1'b0;
         rrsp_id_q    <= '0;
         rrsp_resp_q  <= '0;
         rrsp_data_q  <= '0;
         for (int i = 0; i < NUM_ID; i++) begin
            acc_q[i] <= 2'b00;
         end
      end else begin
         rrsp_valid_q <= r_last_hs;
         if (r_hs) begin
            if (rlast) begin
               rrsp_id_q   <= rid;
               rrsp_resp_q <= r_worst;
               rrsp_data_q <= rdata;
               acc_q[rid]  <= 2'b00;
            end else begin
               acc_q[rid]  <= r_worst;
            end
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   // Valids decode directly from the async-reset state so they drop the
   // instant reset asserts.
   assign awid    = aw_id_q;
   assign awaddr  = aw_addr_q;
   assign awlen   = aw_len_q;
   assign awsize  = aw_size_q;
   assign awburst = live_q ? 2'b01 : 2'b00;
   assign awvalid = (wr_state_q == W_ADDR);

   assign wdata   = wdata_q;
   assign wstrb   = live_q ? '1 : '0;
   assign wvalid  = (wr_state_q == W_DATA);
   assign wlast   = wvalid && (beat_q == aw_len_q);

   assign bready  = live_q;

   assign arid    = ar_id_q;
   assign araddr  = ar_addr_q;
   assign arlen   = ar_len_q;
   assign arsize  = ar_size_q;
   assign arburst = live_q ? 2'b01 : 2'b00;
   assign arvalid = (rd_state_q == R_ADDR);

   assign rready  = live_q;

   assign wrsp_valid = wrsp_valid_q;
   assign wrsp_id    = wrsp_id_q;
   assign wrsp_resp  = wrsp_resp_q;
   assign rrsp_valid = rrsp_valid_q;
   assign rrsp_id    = rrsp_id_q;
   assign rrsp_resp  = rrsp_resp_q;
   assign rrsp_data  = rrsp_data_q;

   assign wr_outstanding = wr_out_q;
   assign rd_outstanding = rd_out_q;

   // ---------------------------------------------------------------- watchdog
`ifdef AXI_MASTER_TIMEOUT_EN
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

   logic [15:0] aw_wd_q, aw_wd_d;
   logic [15:0] w_wd_q,  w_wd_d;
   logic [15:0] ar_wd_q, ar_wd_d;
   logic        timeout_q, timeout_d;

   // Counts consecutive stalled cycles, parking at the limit so it can't wrap.
   function automatic logic [15:0] wd_next(input logic v, input logic r, input logic [15:0] c);
      if (!v || r) begin
         return 16'd0;
      end else if (c >= TO_LIM) begin
         return c;
      end else begin
         return c + 16'd1;
      end
   endfunction

   always_comb begin
      aw_wd_d   = wd_next(awvalid, awready, aw_wd_q);
      w_wd_d    = wd_next(wvalid, wready, w_wd_q);
      ar_wd_d   = wd_next(arvalid, arready, ar_wd_q);
      timeout_d = timeout_q || (aw_wd_d == TO_LIM) || (w_wd_d == TO_LIM) || (ar_wd_d == TO_LIM);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_wd_q   <= '0;
         w_wd_q    <= '0;
         ar_wd_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         aw_wd_q   <= aw_wd_d;
         w_wd_q    <= w_wd_d;
         ar_wd_q   <= ar_wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_master_txn_engine.sv
// tb/tb_axi_master_txn_engine.sv - scoreboard testbench for axi_master_txn_engine

module tb_axi_master_txn_engine;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;

   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [7:0]  cmd_len = '0;
   logic [2:0]  cmd_size = '0;
   logic [3:0]  cmd_id = '0;
   logic [31:0] cmd_seed = '0;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready = 1'b1;

   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready = 1'b0;

   logic [3:0]  bid = '0;
   logic [1:0]  bresp = '0;
   logic        bvalid = 1'b0;
   logic        bready;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready = 1'b1;

   logic [3:0]  rid = '0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready;

   logic        wrsp_valid;
   logic [3:0]  wrsp_id;
   logic [1:0]  wrsp_resp;
   logic        rrsp_valid;
   logic [3:0]  rrsp_id;
   logic [1:0]  rrsp_resp;
   logic [31:0] rrsp_data;
   logic [3:0]  wr_outstanding;
   logic [3:0]  rd_outstanding;
   logic        timeout_err;

   logic        w_toggle = 1'b0;
   logic        w_hold   = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] exp_aw_q[$];
   logic [63:0] exp_ar_q[$];
   logic [63:0] exp_w_q[$];
   logic [63:0] exp_wrsp_q[$];
   logic [63:0] exp_rrsp_q[$];

   axi_master_txn_engine #(
      .ADDR_W(32), .DATA_W(32), .ID_W(4), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .cmd_id(cmd_id), .cmd_seed(cmd_seed),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .wrsp_valid(wrsp_valid), .wrsp_id(wrsp_id), .wrsp_resp(wrsp_resp),
      .rrsp_valid(rrsp_valid), .rrsp_id(rrsp_id), .rrsp_resp(rrsp_resp), .rrsp_data(rrsp_data),
      .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // wready pattern: held low, toggling every cycle, or steadily high.
   always @(posedge clk) begin
      #1;
      wready = w_hold ? 1'b0 : (w_toggle ? ~wready : 1'b1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- scoreboard monitors
   always @(negedge clk) begin
      if (rstn) begin
         if (awvalid && awready) begin
            if (exp_aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
            else check("aw_fields", {15'd0, awid, awlen, awsize, awburst, awaddr}, exp_aw_q.pop_front());
         end
         if (arvalid && arready) begin
            if (exp_ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
            else check("ar_fields", {15'd0, arid, arlen, arsize, arburst, araddr}, exp_ar_q.pop_front());
         end
         if (wvalid) begin
            if (exp_w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
            else begin
               check("w_beat", {27'd0, wlast, wstrb, wdata}, exp_w_q[0]);
               if (wready) void'(exp_w_q.pop_front());
            end
         end
         if (wrsp_valid) begin
            if (exp_wrsp_q.size() == 0) check("wrsp_unexpected", 64'd1, 64'd0);
            else check("wrsp", {58'd0, wrsp_id, wrsp_resp}, exp_wrsp_q.pop_front());
         end
         if (rrsp_valid) begin
            if (exp_rrsp_q.size() == 0) check("rrsp_unexpected", 64'd1, 64'd0);
            else check("rrsp", {26'd0, rrsp_id, rrsp_resp, rrsp_data}, exp_rrsp_q.pop_front());
         end
      end
   end

   // ---------------------------------------------------------------- stimulus helpers
   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [3:0] id, input logic [31:0] seed,
                           input logic [2:0] exp_size);
      logic got;
      @(posedge clk); #1;
      cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_size = size;
      cmd_id = id; cmd_seed = seed; cmd_valid = 1'b1;
      if (wr) begin
         exp_aw_q.push_back({15'd0, id, len, exp_size, 2'b01, addr});
         for (int i = 0; i <= int'(len); i++)
            exp_w_q.push_back({27'd0, (i == int'(len)), 4'hf, seed + 32'(i)});
      end else begin
         exp_ar_q.push_back({15'd0, id, len, exp_size, 2'b01, addr});
      end
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin got = 1'b1; break; end
      end
      if (!got) check("cmd_accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
      @(posedge clk); #1;
      bvalid = 1'b1; bid = id; bresp = resp;
      exp_wrsp_q.push_back({58'd0, id, resp});
      @(posedge clk); #1;
      bvalid = 1'b0;
   endtask

   task automatic send_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                         input logic last, input logic [1:0] worst);
      @(posedge clk); #1;
      rvalid = 1'b1; rid = id; rdata = data; rresp = resp; rlast = last;
      if (last) exp_rrsp_q.push_back({26'd0, id, worst, data});
      @(posedge clk); #1;
      rvalid = 1'b0; rlast = 1'b0;
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!awvalid && !wvalid && !arvalid) begin done = 1'b1; break; end
      end
      if (!done) check("idle_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   // ---------------------------------------------------------------- test sequence
   initial begin
      // Reset state
      #12;
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_valids", {61'd0, awvalid, wvalid, arvalid}, 64'd0);
      check("rst_ready", {62'd0, bready, rready}, 64'd0);
      check("rst_counts", {56'd0, wr_outstanding, rd_outstanding}, 64'd0);
      check("rst_timeout", 64'(timeout_err), 64'd0);
      @(posedge clk); #1; rstn = 1'b1;
      @(posedge clk); @(negedge clk);
      check("post_rst_ready", {62'd0, bready, rready}, 64'd3);

      // Single write, AW the cycle after accept
      send_cmd(1'b1, 32'h1000, 8'd0, 3'd2, 4'd3, 32'hA5A5_0000, 3'd2);
      @(negedge clk);
      check("single_aw_latency", 64'(awvalid), 64'd1);
      check("single_wr_out_pre", 64'(wr_outstanding), 64'd0);
      @(negedge clk);
      check("single_wr_out_live", 64'(wr_outstanding), 64'd1);
      wait_idle();
      send_b(4'd3, 2'b00);
      @(negedge clk);
      check("single_wr_out_done", 64'(wr_outstanding), 64'd0);

      // Burst write with wready stalls; size 5 clamps to 2
      w_toggle = 1'b1;
      send_cmd(1'b1, 32'h2000, 8'd7, 3'd5, 4'd2, 32'h10, 3'd2);
      wait_idle();
      w_toggle = 1'b0;
      send_b(4'd2, 2'b10);
      @(negedge clk);
      check("burst_wr_out_done", 64'(wr_outstanding), 64'd0);

      // Outstanding limit with R held off
      for (int i = 0; i < 4; i++)
         send_cmd(1'b0, 32'h3000 + 32'(i * 16), 8'd0, 3'd1, 4'(4 + i), 32'd0, 3'd1);
      wait_idle();
      check("limit_rd_out", 64'(rd_outstanding), 64'd4);
      @(posedge clk); #1; cmd_write = 1'b0;
      @(negedge clk);
      check("limit_rd_blocked", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1; cmd_write = 1'b1;
      @(negedge clk);
      check("limit_wr_free", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1; cmd_write = 1'b0;
      send_r(4'd4, 32'h44, 2'b00, 1'b1, 2'b00);
      @(negedge clk);
      check("limit_rd_out_3", 64'(rd_outstanding), 64'd3);
      check("limit_rd_reenabled", 64'(cmd_ready), 64'd1);
      send_cmd(1'b0, 32'h3040, 8'd0, 3'd1, 4'd8, 32'd0, 3'd1);
      wait_idle();
      check("limit_rd_out_refill", 64'(rd_outstanding), 64'd4);
      for (int i = 5; i <= 8; i++)
         send_r(4'(i), 32'h40 + 32'(i), 2'b00, 1'b1, 2'b00);
      @(negedge clk);
      check("limit_rd_out_drained", 64'(rd_outstanding), 64'd0);

      // Interleaved reads with per-ID worst response
      send_cmd(1'b0, 32'h5000, 8'd1, 3'd2, 4'd1, 32'd0, 3'd2);
      send_cmd(1'b0, 32'h6000, 8'd1, 3'd2, 4'd2, 32'd0, 3'd2);
      wait_idle();
      send_r(4'd1, 32'h11, 2'b00, 1'b0, 2'b00);
      send_r(4'd2, 32'h21, 2'b10, 1'b0, 2'b00);
      send_r(4'd2, 32'h22, 2'b00, 1'b1, 2'b10);
      send_r(4'd1, 32'h12, 2'b00, 1'b1, 2'b00);
      send_cmd(1'b0, 32'h6100, 8'd0, 3'd2, 4'd2, 32'd0, 3'd2);
      wait_idle();
      send_r(4'd2, 32'h23, 2'b00, 1'b1, 2'b00);
      @(negedge clk);
      check("inter_rd_out", 64'(rd_outstanding), 64'd0);

      // Concurrent B and rlast in the same cycle
      send_cmd(1'b1, 32'h7000, 8'd0, 3'd2, 4'd9, 32'h55, 3'd2);
      send_cmd(1'b0, 32'h8000, 8'd0, 3'd2, 4'd10, 32'd0, 3'd2);
      wait_idle();
      @(posedge clk); #1;
      bvalid = 1'b1; bid = 4'd9; bresp = 2'b00;
      rvalid = 1'b1; rid = 4'd10; rresp = 2'b01; rdata = 32'hBEEF; rlast = 1'b1;
      exp_wrsp_q.push_back({58'd0, 4'd9, 2'b00});
      exp_rrsp_q.push_back({26'd0, 4'd10, 2'b01, 32'hBEEF});
      @(posedge clk); #1;
      bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      @(negedge clk);
      check("both_rsp_same_cycle", {62'd0, wrsp_valid, rrsp_valid}, 64'd3);
      check("both_counts", {56'd0, wr_outstanding, rd_outstanding}, 64'd0);

      // Reset mid-burst
      w_hold = 1'b1;
      send_cmd(1'b1, 32'h9000, 8'd7, 3'd2, 4'd11, 32'h200, 3'd2);
      arready = 1'b0;
      send_cmd(1'b0, 32'hA000, 8'd3, 3'd2, 4'd12, 32'd0, 3'd2);
      @(negedge clk);
      check("midburst_active", {61'd0, awvalid, wvalid, arvalid}, 64'd3);
      check("midburst_wr_out", 64'(wr_outstanding), 64'd1);
      #2; rstn = 1'b0;
      #1;
      check("async_rst_valids", {61'd0, awvalid, wvalid, arvalid}, 64'd0);
      check("async_rst_counts", {56'd0, wr_outstanding, rd_outstanding}, 64'd0);
      exp_w_q.delete(); exp_ar_q.delete();
      w_hold = 1'b0; arready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("rst_no_rsp", {62'd0, wrsp_valid, rrsp_valid}, 64'd0);
      @(posedge clk); #1; rstn = 1'b1;
      @(posedge clk);

      // Unexpected responses: still reported, counters stay at 0
      send_b(4'd5, 2'b11);
      send_r(4'd6, 32'h66, 2'b01, 1'b1, 2'b01);
      @(negedge clk);
      check("unexp_counts", {56'd0, wr_outstanding, rd_outstanding}, 64'd0);

`ifdef AXI_MASTER_TIMEOUT_EN
      // Watchdog on a stalled AW channel
      awready = 1'b0;
      send_cmd(1'b1, 32'hB000, 8'd0, 3'd2, 4'd13, 32'h77, 3'd2);
      for (int i = 0; i < 15; i++) @(posedge clk);
      @(negedge clk);
      check("wd_before_limit", 64'(timeout_err), 64'd0);
      @(posedge clk); @(negedge clk);
      check("wd_at_limit", 64'(timeout_err), 64'd1);
      @(posedge clk); #1; awready = 1'b1;
      wait_idle();
      send_b(4'd13, 2'b00);
      @(negedge clk);
      check("wd_sticky", 64'(timeout_err), 64'd1);
`else
      check("no_watchdog", 64'(timeout_err), 64'd0);
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pending_scoreboard",
            64'(exp_aw_q.size() + exp_ar_q.size() + exp_w_q.size() + exp_wrsp_q.size() + exp_rrsp_q.size()),
            64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
